ssp_uart_cmd_seq: RTL and testbench
===================================

// Module: ssp_uart_cmd_seq
// PURPOSE
//  Upstream command sequencer for ssp_uart: converts parallel register-access commands (valid/ready) into
//  one SSP frame on the core's SSP strobe bus (SSEL, SCK, RA, WnR, En, EOC, DI) and returns the SSP_DO
//  word captured at end-of-cycle as a response. One frame in flight; test benches and the host CPU
//  bridge use it to program and poll the UART.
// PARAMETERS
//  SCK_DIV  4  Clk cycles per SCK half-period; legal range 1..255
// PORTS
//  Clk        in   1   system clock; all logic on rising edge
//  Rst        in   1   synchronous reset, active-high
//  cmd_valid  in   1   command offered
//  cmd_ready  out  1   command accepted when cmd_valid & cmd_ready
//  cmd_ra     in   3   target register address
//  cmd_wnr    in   1   1 = write, 0 = read
//  cmd_data   in   12  write data (ignored for reads; still driven onto SSP_DI)
//  rsp_valid  out  1   response held until rsp_ready
//  rsp_ready  in   1   response consumed when rsp_valid & rsp_ready
//  rsp_data   out  12  SSP_DO captured at EOC (status for writes, register for reads)
//  busy       out  1   1 from acceptance until the response is consumed
//  SSP_SSEL   out  1   slave select, active-high
//  SSP_SCK    out  1   serial clock, idles low
//  SSP_RA     out  3   register address, stable for whole frame
//  SSP_WnR    out  1   command, stable for whole frame
//  SSP_En     out  1   data phase (bits 11:0) active
//  SSP_EOC    out  1   end of cycle (bit 0)
//  SSP_DI     out  12  data in, stable for whole frame
//  SSP_DO     in   12  data out from ssp_uart
// BEHAVIOUR
//  Reset: cmd_ready=1, rsp_valid=0, rsp_data=0, busy=0, all SSP_* outputs 0. Reset mid-frame aborts the
//   frame; outputs return to reset values on the next edge; no response is produced.
//  FSM: IDLE -> SETUP -> HDR -> DATA -> HOLD -> RESP -> IDLE.
//   IDLE : cmd_ready=1. On accept, latch ra/wnr/data into SSP_RA/SSP_WnR/SSP_DI; go SETUP.
//   SETUP: SSEL=1, SCK=0 for SCK_DIV cycles.
//   HDR  : 4 bit periods (RA[2:0], WnR); each bit = SCK_DIV cycles SCK=0 then SCK_DIV cycles SCK=1.
//   DATA : 12 bit periods, same timing; SSP_En=1 throughout; SSP_EOC=1 during the last bit period only.
//   HOLD : SCK=0, En=0, EOC=0, SSEL=1 for SCK_DIV cycles; then SSEL=0.
//   RESP : rsp_valid=1 until rsp_ready; then IDLE.
//  Capture: rsp_data <= SSP_DO on the Clk edge where SCK rises during the EOC bit (SCK half-period
//   counter wrap with EOC=1 and SCK=0).
//  Latency: accept at edge N -> rsp_valid first high after edge N+34*SCK_DIV (34 half-periods total).
//  cmd_ready=0 outside IDLE; a second command waits; rsp_ready high early is harmless.
//  Simultaneous rsp_ready & new cmd_valid in RESP: response retires; new cmd accepted the following
//   cycle (IDLE), never the same cycle.
//  Counters: half-period counter 8 bit, counts SCK_DIV-1..0 and reloads; bit counter 4 bit, counts
//   15..0 (15..12 header, 11..0 data = SSP data bit index); no wrap beyond 0 — terminal count ends phase.
//  SSP_RA/WnR/DI hold last frame value in IDLE (not cleared) except at reset.
// STRUCTURE
//  ssp_uart_pkg: seq_state_e enum, SSP_RA_W=3, SSP_DATA_W=12, SSP_HDR_BITS=4, SSP_FRAME_BITS=16.
//  Sub-module ssp_sck_gen: half-period counter, SCK level, rise/fall strobes, enable input.
//  Top: FSM, bit counter, frame latches, response register.
// TESTING
//  1 Write: SCK_DIV=4, cmd ra=3 wnr=1 data=0x0A5 -> SSEL high 136 cycles, 16 SCK rises, En high for
//    12 bits, EOC 1 bit, SSP_RA=3 SSP_DI=0x0A5; rsp_valid after 136 cycles.
//  2 Read: SSP_DO model returns 0x5C3 during EOC, cmd ra=0 wnr=0 -> rsp_data=0x5C3, busy clears on rsp_ready.
//  3 Backpressure: rsp_ready=0 for 50 cycles with cmd_valid held -> cmd_ready stays 0, rsp_data stable,
//    second frame starts one cycle after rsp handshake.
//  4 SCK_DIV=1: back-to-back reads -> SCK toggles every cycle, latency 34 cycles per command.
//  5 Reset at bit 7 of DATA -> next cycle SSEL=0, SCK=0, En=0, rsp_valid=0, cmd_ready=1.
//  6 Protocol checker on all tests: En never high in HDR; EOC implies En; SCK only toggles while SSEL=1.

Source files
------------

// File: rtl/ssp_uart_pkg.sv
// Shared types and constants for the ssp_uart command sequencer.
//   seq_state_e     : sequencer FSM states
//   SSP_RA_W        : register address width
//   SSP_DATA_W      : SSP data word width
//   SSP_HDR_BITS    : header bits per frame (RA[2:0], WnR)
//   SSP_FRAME_BITS  : total bit periods per frame
package ssp_uart_pkg;

    localparam int SSP_RA_W       = 3;
    localparam int SSP_DATA_W     = 12;
    localparam int SSP_HDR_BITS   = 4;
    localparam int SSP_FRAME_BITS = SSP_HDR_BITS + SSP_DATA_W;

    // Bit counter values: first header bit, and the last header bit before data.
    localparam logic [3:0] BIT_FIRST    = 4'(SSP_FRAME_BITS - 1);
    localparam logic [3:0] BIT_HDR_LAST = 4'(SSP_DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HDR,
        ST_DATA,
        ST_HOLD,
        ST_RESP
    } seq_state_e;

endpackage

// File: rtl/ssp_uart_cmd_seq_if.sv
// Host-side command/response channel of the ssp_uart command sequencer.
//   cmd_valid/cmd_ready : command handshake; cmd_ra, cmd_wnr, cmd_data payload
//   rsp_valid/rsp_ready : response handshake; rsp_data payload (SSP_DO at EOC)
//   master : host issuing commands; slave : the sequencer
interface ssp_uart_cmd_seq_if;
    import ssp_uart_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [SSP_RA_W-1:0]   cmd_ra;
    logic                  cmd_wnr;
    logic [SSP_DATA_W-1:0] cmd_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [SSP_DATA_W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_ra, cmd_wnr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_ra, cmd_wnr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/ssp_uart_cmd_seq_sck_gen.sv
// SCK generator: half-period counter plus SCK level and edge strobes.
//   Clk, Rst  : clock, synchronous active-high reset
//   run       : counter runs while high, held at reload otherwise
//   toggle_en : SCK toggles on each half-period wrap while high, forced low otherwise
//   wrap      : last cycle of the current half-period
//   sck       : SCK level
//   rise/fall : wrap cycles on which SCK goes high / low at the next edge
module ssp_sck_gen #(
    parameter int SCK_DIV = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic run,
    input  logic toggle_en,
    output logic wrap,
    output logic sck,
    output logic rise,
    output logic fall
);
    localparam logic [7:0] RELOAD = 8'(SCK_DIV - 1);

    logic [7:0] hc_q;

    assign wrap = run && (hc_q == 8'd0);
    assign rise = wrap && toggle_en && !sck;
    assign fall = wrap && toggle_en && sck;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hc_q <= RELOAD;
            sck  <= 1'b0;
        end else begin
            // Parked at reload while idle so the first half-period is full length.
            if (!run || wrap) hc_q <= RELOAD;
            else              hc_q <= hc_q - 8'd1;

            if (!toggle_en) sck <= 1'b0;
            else if (wrap)  sck <= !sck;
        end
    end

endmodule

// File: rtl/ssp_uart_cmd_seq.sv
// Command sequencer: turns one accepted register-access command into one SSP
// frame and returns SSP_DO captured at end-of-cycle as the response.
//   Clk, Rst      : clock, synchronous active-high reset
//   bus (slave)   : cmd valid/ready + ra/wnr/data, rsp valid/ready + data
//   busy          : high from acceptance until the response is consumed
//   SSP_SSEL/SCK  : slave select and serial clock (SCK idles low)
//   SSP_RA/WnR/DI : frame fields, held from acceptance until the next one
//   SSP_En/EOC    : data phase and last-bit strobes
//   SSP_DO        : data returned by ssp_uart
module ssp_uart_cmd_seq
    import ssp_uart_pkg::*;
#(
    parameter int SCK_DIV = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    ssp_uart_cmd_seq_if.slave     bus,
    output logic                  busy,
    output logic                  SSP_SSEL,
    output logic                  SSP_SCK,
    output logic [SSP_RA_W-1:0]   SSP_RA,
    output logic                  SSP_WnR,
    output logic                  SSP_En,
    output logic                  SSP_EOC,
    output logic [SSP_DATA_W-1:0] SSP_DI,
    input  logic [SSP_DATA_W-1:0] SSP_DO
);
    seq_state_e state_q, state_d;
    logic [3:0] bit_q;
    logic       run, toggle_en, wrap, rise, fall, accept;

    ssp_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck_gen (
        .Clk       (Clk),
        .Rst       (Rst),
        .run       (run),
        .toggle_en (toggle_en),
        .wrap      (wrap),
        .sck       (SSP_SCK),
        .rise      (rise),
        .fall      (fall)
    );

    assign accept = bus.cmd_valid && bus.cmd_ready;

    always_ff @(posedge Clk) begin
        if (Rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d       = state_q;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        busy          = 1'b1;
        SSP_SSEL      = 1'b0;
        SSP_En        = 1'b0;
        SSP_EOC       = 1'b0;
        run           = 1'b0;
        toggle_en     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                busy          = 1'b0;
                if (bus.cmd_valid) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                SSP_SSEL = 1'b1;
                run      = 1'b1;
                if (wrap) state_d = ST_HDR;
            end
            ST_HDR: begin
                SSP_SSEL  = 1'b1;
                run       = 1'b1;
                toggle_en = 1'b1;
                // A bit period ends on its SCK falling edge.
                if (fall && bit_q == BIT_HDR_LAST) state_d = ST_DATA;
            end
            ST_DATA: begin
                SSP_SSEL  = 1'b1;
                run       = 1'b1;
                toggle_en = 1'b1;
                SSP_En    = 1'b1;
                SSP_EOC   = (bit_q == 4'd0);
                if (fall && bit_q == 4'd0) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                SSP_SSEL = 1'b1;
                run      = 1'b1;
                if (wrap) state_d = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            bit_q        <= '0;
            SSP_RA       <= '0;
            SSP_WnR      <= 1'b0;
            SSP_DI       <= '0;
            bus.rsp_data <= '0;
        end else begin
            if (accept) begin
                SSP_RA  <= bus.cmd_ra;
                SSP_WnR <= bus.cmd_wnr;
                SSP_DI  <= bus.cmd_data;
            end

            // Counts 15..0 and stops at 0; terminal count ends the data phase.
            if (state_q == ST_SETUP && wrap)  bit_q <= BIT_FIRST;
            else if (fall && bit_q != 4'd0)   bit_q <= bit_q - 4'd1;

            // Sample SSP_DO as SCK rises in the EOC bit.
            if (rise && SSP_EOC) bus.rsp_data <= SSP_DO;
        end
    end

endmodule

// File: tb/tb_ssp_uart_cmd_seq.sv
// Self-checking bench for ssp_uart_cmd_seq: one instance with SCK_DIV=4 and one
// with SCK_DIV=1, selected by 'sel'. Frame waveforms are compared cycle by cycle
// against an arithmetic model of the frame (half-period index -> expected levels).
module tb_ssp_uart_cmd_seq;
    import ssp_uart_pkg::*;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic        sel       = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_wnr   = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [2:0]  cmd_ra    = '0;
    logic [11:0] cmd_data  = '0;
    logic [11:0] do_val    = '0;

    ssp_uart_cmd_seq_if bus4 ();
    ssp_uart_cmd_seq_if bus1 ();

    assign bus4.cmd_valid = cmd_valid & ~sel;
    assign bus4.rsp_ready = rsp_ready & ~sel;
    assign bus4.cmd_ra    = cmd_ra;
    assign bus4.cmd_wnr   = cmd_wnr;
    assign bus4.cmd_data  = cmd_data;
    assign bus1.cmd_valid = cmd_valid & sel;
    assign bus1.rsp_ready = rsp_ready & sel;
    assign bus1.cmd_ra    = cmd_ra;
    assign bus1.cmd_wnr   = cmd_wnr;
    assign bus1.cmd_data  = cmd_data;

    logic        busy4, ssel4, sck4, wnr4, en4, eoc4;
    logic [2:0]  ra4;
    logic [11:0] di4, do4;
    logic        busy1, ssel1, sck1, wnr1, en1, eoc1;
    logic [2:0]  ra1;
    logic [11:0] di1, do1;

    // Slave model: valid data only while EOC is set and SCK is low.
    assign do4 = (eoc4 && !sck4) ? do_val : ~do_val;
    assign do1 = (eoc1 && !sck1) ? do_val : ~do_val;

    ssp_uart_cmd_seq #(.SCK_DIV(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .bus(bus4), .busy(busy4),
        .SSP_SSEL(ssel4), .SSP_SCK(sck4), .SSP_RA(ra4), .SSP_WnR(wnr4),
        .SSP_En(en4), .SSP_EOC(eoc4), .SSP_DI(di4), .SSP_DO(do4)
    );

    ssp_uart_cmd_seq #(.SCK_DIV(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .bus(bus1), .busy(busy1),
        .SSP_SSEL(ssel1), .SSP_SCK(sck1), .SSP_RA(ra1), .SSP_WnR(wnr1),
        .SSP_En(en1), .SSP_EOC(eoc1), .SSP_DI(di1), .SSP_DO(do1)
    );

    typedef struct packed {
        logic ssel, sck, en, eoc, rsp_valid, cmd_ready, busy;
    } obs_t;

    localparam obs_t OBS_IDLE = 7'b0000010;

    obs_t        obs;
    logic [2:0]  o_ra;
    logic        o_wnr;
    logic [11:0] o_di, o_rsp;

    always_comb begin
        if (sel) begin
            obs   = {ssel1, sck1, en1, eoc1, bus1.rsp_valid, bus1.cmd_ready, busy1};
            o_ra  = ra1;
            o_wnr = wnr1;
            o_di  = di1;
            o_rsp = bus1.rsp_data;
        end else begin
            obs   = {ssel4, sck4, en4, eoc4, bus4.rsp_valid, bus4.cmd_ready, busy4};
            o_ra  = ra4;
            o_wnr = wnr4;
            o_di  = di4;
            o_rsp = bus4.rsp_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Protocol rules on both instances every cycle.
    function automatic bit proto_bad(input logic ssel, sck, en, eoc, sck_p);
        return (eoc && !en) || (en && !ssel) || ((sck !== sck_p) && !ssel);
    endfunction

    int   proto_err = 0;
    logic sck4_p = 1'b0, sck1_p = 1'b0;
    always @(negedge Clk) begin
        if (!Rst)
            proto_err <= proto_err + int'(proto_bad(ssel4, sck4, en4, eoc4, sck4_p))
                                   + int'(proto_bad(ssel1, sck1, en1, eoc1, sck1_p));
        sck4_p <= sck4;
        sck1_p <= sck1;
    end

    // Frame model: k = clock edges since acceptance, d = SCK_DIV.
    // Half-period 0 is setup, 1..32 are 16 bits (low half then high half),
    // 33 is hold, then the response is pending.
    function automatic obs_t model(input int k, input int d);
        obs_t o;
        int   h;
        int   b;
        o = '0;
        h = k / d;
        if (h < 34) begin
            o.ssel = 1'b1;
            o.busy = 1'b1;
            if (h >= 1 && h <= 32) begin
                b     = (h - 1) / 2;
                o.sck = ((h - 1) % 2) == 1;
                o.en  = (b >= 4);
                o.eoc = (b == 15);
            end
        end else begin
            o.rsp_valid = 1'b1;
            o.busy      = 1'b1;
        end
        return o;
    endfunction

    int accept_wait;

    // Runs one command through the selected instance; starts and ends at a negedge.
    // hold_next keeps cmd_valid high with ra/data inverted for the following frame.
    task automatic do_frame(input string name, input logic [2:0] ra, input logic wnr,
                            input logic [11:0] data, input logic [11:0] dov,
                            input int rsp_delay, input bit early, input bit hold_next);
        int   d;
        int   waited;
        int   bad_k;
        int   rises;
        int   ssel_cyc;
        bit   bp_bad;
        logic prev_sck;
        obs_t exp_o;
        d        = sel ? 1 : 4;
        waited   = 0;
        bad_k    = -1;
        rises    = 0;
        ssel_cyc = 0;
        bp_bad   = 1'b0;
        prev_sck = 1'b0;
        cmd_ra   = ra;
        cmd_wnr  = wnr;
        cmd_data = data;
        do_val   = dov;
        cmd_valid = 1'b1;
        while (!obs.cmd_ready && waited < 100) begin
            @(negedge Clk);
            waited++;
        end
        accept_wait = waited;
        check({name, ".accept"}, 32'(obs.cmd_ready), 32'd1);
        if (!obs.cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        @(negedge Clk);
        if (hold_next) begin
            cmd_ra   = ~ra;
            cmd_data = ~data;
        end else begin
            cmd_valid = 1'b0;
        end
        if (early) rsp_ready = 1'b1;
        for (int k = 0; k <= 34 * d; k++) begin
            if (k > 0) @(negedge Clk);
            exp_o = model(k, d);
            if (bad_k < 0 && (obs !== exp_o || o_ra !== ra || o_wnr !== wnr || o_di !== data))
                bad_k = k;
            if (obs.sck && !prev_sck) rises++;
            prev_sck = obs.sck;
            if (obs.ssel) ssel_cyc++;
        end
        check({name, ".first_bad_cycle"}, 32'(bad_k), 32'hFFFF_FFFF);
        check({name, ".sck_rises"}, 32'(rises), 32'd16);
        check({name, ".ssel_cycles"}, 32'(ssel_cyc), 32'(34 * d));
        check({name, ".rsp_data"}, 32'(o_rsp), 32'(dov));
        for (int i = 0; i < rsp_delay; i++) begin
            @(negedge Clk);
            if (!obs.rsp_valid || obs.cmd_ready || obs.ssel || o_rsp !== dov) bp_bad = 1'b1;
        end
        if (rsp_delay > 0) check({name, ".rsp_held"}, 32'(bp_bad), 32'd0);
        rsp_ready = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        rsp_ready = 1'b0;
        check({name, ".retired"}, 32'(obs), 32'(OBS_IDLE));
        check({name, ".fields_held"}, 32'({o_ra, o_wnr, o_di}), 32'({ra, wnr, data}));
    endtask

    typedef struct {
        logic [2:0]  ra;
        logic        wnr;
        logic [11:0] data;
        logic [11:0] dov;
        int          rsp_delay;
        bit          early;
        logic [11:0] exp_rsp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   idle_bad;
        vec_t v;

        vecs[0] = '{ra: 3'd3, wnr: 1'b1, data: 12'h0A5, dov: 12'h0F0, rsp_delay: 0, early: 1'b0, exp_rsp: 12'h0F0};
        vecs[1] = '{ra: 3'd0, wnr: 1'b0, data: 12'h000, dov: 12'h5C3, rsp_delay: 2, early: 1'b0, exp_rsp: 12'h5C3};
        vecs[2] = '{ra: 3'd7, wnr: 1'b1, data: 12'hFFF, dov: 12'h000, rsp_delay: 0, early: 1'b1, exp_rsp: 12'h000};
        vecs[3] = '{ra: 3'd5, wnr: 1'b0, data: 12'h800, dov: 12'hFFF, rsp_delay: 1, early: 1'b0, exp_rsp: 12'hFFF};

        // Reset state of both instances.
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        sel = 1'b0;
        #0;
        check("reset.d4.outputs", 32'(obs), 32'(OBS_IDLE));
        check("reset.d4.fields", 32'({o_ra, o_wnr, o_di, o_rsp}), 32'd0);
        sel = 1'b1;
        #0;
        check("reset.d1.outputs", 32'(obs), 32'(OBS_IDLE));
        check("reset.d1.fields", 32'({o_ra, o_wnr, o_di, o_rsp}), 32'd0);

        // Directed table, SCK_DIV=4.
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = vecs[i];
            do_frame($sformatf("vec%0d", i), v.ra, v.wnr, v.data, v.dov, v.rsp_delay, v.early, 1'b0);
            check($sformatf("vec%0d.rsp_expected", i), 32'(o_rsp), 32'(v.exp_rsp));
        end

        // Backpressure: response stalled 50 cycles with the next command pending.
        do_frame("bp_a", 3'd2, 1'b1, 12'h3A6, 12'h1E1, 50, 1'b0, 1'b1);
        do_frame("bp_b", 3'd5, 1'b1, 12'hC59, 12'h7B4, 0, 1'b0, 1'b0);
        check("bp_b.accept_next_cycle", 32'(accept_wait), 32'd0);

        // SCK_DIV=1 back-to-back reads.
        sel = 1'b1;
        do_frame("d1_r0", 3'd1, 1'b0, 12'h123, 12'hABC, 0, 1'b0, 1'b1);
        do_frame("d1_r1", 3'd6, 1'b0, 12'hEDC, 12'h456, 0, 1'b0, 1'b1);
        check("d1_r1.back_to_back", 32'(accept_wait), 32'd0);
        do_frame("d1_r2", 3'd1, 1'b0, 12'h123, 12'h9E7, 0, 1'b1, 1'b0);
        check("d1_r2.back_to_back", 32'(accept_wait), 32'd0);

        // Randomized frames alternating between both instances.
        for (int i = 0; i < 8; i++) begin
            int  dly;
            bit  erl;
            sel = 1'(i % 2);
            dly = int'($urandom_range(0, 3));
            erl = (dly == 0) && ($urandom_range(0, 1) == 1);
            do_frame($sformatf("rnd%0d", i), 3'($urandom), 1'($urandom), 12'($urandom),
                     12'($urandom), dly, erl, 1'b0);
        end

        // Reset while data bit 7 is on the wire (frame bit 8, half-period 17).
        sel       = 1'b0;
        cmd_ra    = 3'd5;
        cmd_wnr   = 1'b1;
        cmd_data  = 12'h3C7;
        do_val    = 12'h111;
        cmd_valid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        cmd_valid = 1'b0;
        repeat (68) @(negedge Clk);
        check("midrst.en_before", 32'({obs.ssel, obs.en, obs.eoc}), 32'b110);
        Rst = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        check("midrst.outputs", 32'(obs), 32'(OBS_IDLE));
        check("midrst.fields", 32'({o_ra, o_wnr, o_di, o_rsp}), 32'd0);
        idle_bad = 1'b0;
        repeat (160) begin
            @(negedge Clk);
            if (obs !== OBS_IDLE) idle_bad = 1'b1;
        end
        check("midrst.no_response", 32'(idle_bad), 32'd0);

        check("protocol_violations", 32'(proto_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
